instr_encoder_loader: RTL

- Instruction encoder and program loader. It is the write-side counterpart of the control decoder.
- Accepts field-level instruction requests (class, register numbers, funct, shamt, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and buffers it in a small FIFO.
- Writes the buffered words into instruction memory at sequential word addresses, so test programs can be loaded before the single-cycle CPU runs.

---
 rtl/instr_encoder_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Instruction encoder and program loader.
// Field-level requests are packed into 32-bit MIPS words, buffered in a small
// FIFO and written to instruction memory at sequential word addresses.
// Write-side outputs are registered copies of the FIFO head, so a word
// accepted at one edge is offered to memory from the following cycle on.
module instr_encoder_loader #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_kind_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        shamt_i,
   input  logic [5:0]        funct_i,
   input  logic [15:0]       imm_i,
   input  logic              last_i,
   output logic              mem_we_o,
   output logic [ADDR_W+1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   count_o,
   output logic              err_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Sum width wide enough for count + occupancy whatever the parameters
   localparam int SW = (ADDR_W + 2 > PW + 2) ? ADDR_W + 2 : PW + 2;
   localparam logic [SW-1:0] CAP       = SW'(1) << ADDR_W;
   localparam logic [PW:0]   DEPTH_VAL = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [31:0]         fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [PW:0]         occ;
   logic [ADDR_W-1:0]   wptr;

   logic                accept;
   logic                push;
   logic                pop;
   logic                mem_full;
   logic                clr_session;
   logic                set_err;
   logic [31:0]         enc_word;
   logic [PW:0]         occ_nx;
   logic [PW:0]         occ_left;
   logic [PW-1:0]       rd_nx;
   logic [PW-1:0]       wr_nx;
   logic [ADDR_W:0]     cnt_nx;
   logic [ADDR_W-1:0]   wptr_nx;
   logic                err_nx;
   logic [31:0]         head_nx;
   logic                ready_nx;

   // Pack request fields into a MIPS word; unknown kinds yield zero
   function automatic logic [31:0] encode(
      input logic [1:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm
   );
      logic [31:0] w;
      case (kind)
         2'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
         2'd1:    w = {6'b001000, rs, rt, imm};
         2'd2:    w = {6'b000100, rs, rt, imm};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   assign mem_addr_o = {wptr, 2'b00};
   assign accept     = req_valid_i & req_ready_o;
   assign push       = accept & (req_kind_i != 2'd3);
   assign pop        = mem_we_o & mem_ready_i;
   assign enc_word   = encode(req_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i);
   assign mem_full   = ((SW'(count_o) + SW'(occ)) == CAP);

   // Next-state logic and session control
   always_comb begin
      state_nx    = state;
      clr_session = 1'b0;
      set_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nx    = S_LOAD;
               clr_session = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_LOAD: begin
            if (accept && last_i) begin
               state_nx = S_DRAIN;
            end else if (req_valid_i && mem_full) begin
               // Request would overflow memory: refuse it and wind down
               state_nx = S_DRAIN;
               set_err  = 1'b1;
            end else begin
               state_nx = S_LOAD;
            end
            if (accept && (req_kind_i == 2'd3)) begin
               set_err = 1'b1;
            end else begin
               set_err = set_err;
            end
         end
         S_DRAIN: begin
            if ((occ == '0) && !mem_we_o) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_DRAIN;
            end
         end
         S_DONE: begin
            if (start_i) begin
               state_nx    = S_LOAD;
               clr_session = 1'b1;
            end else begin
               state_nx = S_DONE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath next values: FIFO pointers, counters and the next head word
   always_comb begin
      occ_nx   = occ + (PW + 1)'(push) - (PW + 1)'(pop);
      occ_left = occ - (PW + 1)'(pop);
      rd_nx    = rd_ptr + PW'(pop);
      wr_nx    = wr_ptr + PW'(push);
      if (clr_session) begin
         cnt_nx  = '0;
         wptr_nx = ADDR_W'(BASE_ADDR);
         err_nx  = 1'b0;
      end else begin
         cnt_nx  = count_o + (ADDR_W + 1)'(pop);
         wptr_nx = wptr + ADDR_W'(pop);
         err_nx  = err_o | set_err;
      end
      // When every stored word leaves this edge, the new head is the word
      // being pushed now (it is not yet visible in fifo_mem)
      if (occ_nx == '0) begin
         head_nx = mem_data_o;
      end else if (occ_left == '0) begin
         head_nx = enc_word;
      end else begin
         head_nx = fifo_mem[rd_nx];
      end
      ready_nx = (state_nx == S_LOAD) && (occ_nx != DEPTH_VAL) &&
                 ((SW'(cnt_nx) + SW'(occ_nx)) != CAP);
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= enc_word;
      end
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occ         <= '0;
         wptr        <= ADDR_W'(BASE_ADDR);
         count_o     <= '0;
         err_o       <= 1'b0;
         req_ready_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_data_o  <= 32'h0000_0000;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state       <= state_nx;
         rd_ptr      <= rd_nx;
         wr_ptr      <= wr_nx;
         occ         <= occ_nx;
         wptr        <= wptr_nx;
         count_o     <= cnt_nx;
         err_o       <= err_nx;
         req_ready_o <= ready_nx;
         mem_we_o    <= (occ_nx != '0);
         mem_data_o  <= head_nx;
         busy_o      <= (state_nx == S_LOAD) || (state_nx == S_DRAIN);
         done_o      <= (state_nx == S_DONE);
      end
   end

endmodule
